// File: rtl/crc16_pkg.sv
// Shared constants, state encoding and the LFSR step function for the
// serial CRC-16 encoder/checker pair (poly 0x8005, init 0, no reflection,
// no final XOR).
package crc16_pkg;

    localparam int              CRC_W    = 16;
    localparam logic [15:0]     CRC_POLY = 16'h8005;
    localparam logic [15:0]     CRC_INIT = 16'h0000;

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2,
        DONE = 2'd3
    } crc_state_e;

    // One MSB-first LFSR step: shift left, fold the polynomial in when the
    // feedback bit (outgoing MSB xor incoming bit) is set.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] r,
                                                  input logic             b);
        logic fb;
        fb       = r[CRC_W-1] ^ b;
        crc_step = {r[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & CRC_POLY);
    endfunction

endpackage

// File: rtl/crc16_serial_lfsr.sv
// Bit-serial CRC-16 shift register with synchronous clear and shift enable.
// Shared between the encoder and the checker; clear wins over shift.
module crc16_serial_lfsr
    import crc16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] r,
    output logic             zero
);

    logic [CRC_W-1:0] r_d;
    logic [CRC_W-1:0] r_q;

    // Next register value: clear to the init value, step on a sampled bit, else hold.
    always_comb begin
        r_d = r_q;
        if (clr) begin
            r_d = CRC_INIT;
        end else if (shift_en) begin
            r_d = crc_step(r_q, bit_in);
        end else begin
            r_d = r_q;
        end
    end

    // Register state, asynchronously reset to the init value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= CRC_INIT;
        end else begin
            r_q <= r_d;
        end
    end

    assign r    = r_q;
    assign zero = (r_q == {CRC_W{1'b0}});

endmodule

// File: rtl/crc16_serial_checker.sv
// Serial CRC-16 checker: receives data bits followed by the 16 appended CRC
// bits (MSB first), passes data through with one cycle of delay and reports
// a pass/fail verdict once per frame.
// Optional feature macro: CRC16_CHK_ERRCNT_EN adds a saturating 8-bit
// failed-frame counter on port err_cnt.
module crc16_serial_checker
    import crc16_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       d_finish,
    input  logic       crc_in,
    output logic       data_out,
    output logic       data_valid,
    output logic       chk_valid,
    output logic       crc_ok,
    output logic       crc_err
`ifdef CRC16_CHK_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    crc_state_e       state_d,      state_q;
    logic [CNT_W-1:0] cnt_d,        cnt_q;
    logic             data_out_d,   data_out_q;
    logic             data_valid_d, data_valid_q;
    logic             chk_valid_d,  chk_valid_q;
    logic             crc_ok_d,     crc_ok_q;
    logic             crc_err_d,    crc_err_q;

    logic             lfsr_clr_s;
    logic             lfsr_shift_s;
    logic [CRC_W-1:0] lfsr_r_s;
    logic             lfsr_zero_s;

    crc16_serial_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .clr      (lfsr_clr_s),
        .shift_en (lfsr_shift_s),
        .bit_in   (crc_in),
        .r        (lfsr_r_s),
        .zero     (lfsr_zero_s)
    );

    // Frame FSM: next state, CRC bit counter, pass-through and verdict values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        chk_valid_d  = 1'b0;
        crc_ok_d     = crc_ok_q;
        crc_err_d    = crc_err_q;
        lfsr_clr_s   = 1'b0;
        lfsr_shift_s = 1'b0;
        case (state_q)
            IDLE: begin
                // Keep the LFSR parked at init so a frame can start on any cycle.
                lfsr_clr_s = 1'b1;
                cnt_d      = CNT_ZERO;
                if (load) begin
                    state_d   = DATA;
                    crc_ok_d  = 1'b0;
                    crc_err_d = 1'b0;
                end else begin
                    state_d   = IDLE;
                end
            end
            DATA: begin
                lfsr_shift_s = 1'b1;
                data_out_d   = crc_in;
                data_valid_d = 1'b1;
                if (d_finish) begin
                    state_d = CRC;
                end else begin
                    state_d = DATA;
                end
            end
            CRC: begin
                lfsr_shift_s = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = CRC;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                // Data plus its own CRC leaves the remainder at zero on a good frame.
                crc_ok_d    = lfsr_zero_s;
                crc_err_d   = ~lfsr_zero_s;
                chk_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d    = IDLE;
                cnt_d      = CNT_ZERO;
                lfsr_clr_s = 1'b1;
            end
        endcase
    end

    // State, counter and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= CNT_ZERO;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            chk_valid_q  <= 1'b0;
            crc_ok_q     <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            chk_valid_q  <= chk_valid_d;
            crc_ok_q     <= crc_ok_d;
            crc_err_q    <= crc_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign chk_valid  = chk_valid_q;
    assign crc_ok     = crc_ok_q;
    assign crc_err    = crc_err_q;

`ifdef CRC16_CHK_ERRCNT_EN
    logic [7:0] err_cnt_d, err_cnt_q;

    // Count failed verdicts, sticking at 255; only reset clears the count.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == DONE) && !lfsr_zero_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc16_serial_checker.sv
// Self-checking bench for crc16_serial_checker: a table of frames driven
// back-to-back or with gaps, a scoreboard of expected verdicts popped on
// chk_valid, plus hand-written reset-abort and saturation sequences.
module tb_crc16_serial_checker;

    logic clk = 1'b0;
    logic rst;
    logic load;
    logic d_finish;
    logic crc_in;
    logic data_out;
    logic data_valid;
    logic chk_valid;
    logic crc_ok;
    logic crc_err;
`ifdef CRC16_CHK_ERRCNT_EN
    logic [7:0] err_cnt;
    int         exp_err_cnt = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [71:0] data;
        int          len;
        logic [15:0] crc;
        logic        exp_ok;
        int          gap;
        logic        noise;
    } frame_t;

    typedef struct {
        logic [71:0] data;
        int          len;
        logic        exp_ok;
        int          ed_cyc;
    } exp_t;

    localparam int NTBL = 10;
    frame_t tbl [NTBL];
    exp_t   exp_q [$];
    logic   rx_q  [$];
    exp_t        mon_e;
    logic [71:0] mon_rxv;
    frame_t      bad_frame;
    logic [7:0]  abort_byte;

    crc16_serial_checker dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .d_finish   (d_finish),
        .crc_in     (crc_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .chk_valid  (chk_valid),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err)
`ifdef CRC16_CHK_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one frame starting in the current (post-edge) cycle; returns in the DONE cycle.
    task automatic send_frame(input frame_t f);
        exp_t e;
        load = 1'b1;
        @(posedge clk); #1;
        check("verdict_cleared_ok", 72'(crc_ok), 72'd0);
        check("verdict_cleared_err", 72'(crc_err), 72'd0);
        load = f.noise;
        for (int i = 0; i < f.len; i++) begin
            crc_in   = f.data[f.len - 1 - i];
            d_finish = (i == f.len - 1);
            @(posedge clk); #1;
        end
        e.data   = f.data;
        e.len    = f.len;
        e.exp_ok = f.exp_ok;
        e.ed_cyc = cyc;
        exp_q.push_back(e);
        d_finish = 1'b0;
        for (int i = 0; i < 16; i++) begin
            crc_in = f.crc[15 - i];
            if (f.noise) d_finish = i[0];
            @(posedge clk); #1;
        end
        crc_in   = 1'b0;
        d_finish = 1'b0;
        load     = f.noise;
    endtask

    // Step into the chk_valid cycle, then idle for the requested gap.
    task automatic after_frame(input int gap);
        @(posedge clk); #1;
        if (gap > 0) begin
            load     = 1'b0;
            d_finish = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Scoreboard monitor: collect passed-through data bits and score each verdict.
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid) rx_q.push_back(data_out);
            if (chk_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_chk_valid", 72'd1, 72'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("crc_ok", 72'(crc_ok), 72'(mon_e.exp_ok));
                    check("crc_err", 72'(crc_err), 72'(!mon_e.exp_ok));
                    check("verdict_latency", 72'(cyc - mon_e.ed_cyc), 72'd17);
                    check("data_valid_count", 72'(rx_q.size()), 72'(mon_e.len));
                    mon_rxv = '0;
                    foreach (rx_q[i]) mon_rxv = {mon_rxv[70:0], rx_q[i]};
                    check("data_out_bits", mon_rxv, mon_e.data);
                    rx_q.delete();
`ifdef CRC16_CHK_ERRCNT_EN
                    if (!mon_e.exp_ok && exp_err_cnt < 255) exp_err_cnt++;
                    check("err_cnt", 72'(err_cnt), 72'(exp_err_cnt));
`endif
                end
            end
        end
    end

    initial begin
        tbl[0] = '{72'h01, 8, 16'h8005, 1'b1, 0, 1'b0};
        tbl[1] = '{72'h313233343536373839, 72, 16'hFEE8, 1'b1, 2, 1'b0};
        tbl[2] = '{72'h313233343536373839 ^ 72'h20, 72, 16'hFEE8, 1'b0, 0, 1'b0};
        tbl[3] = '{72'h0, 1, 16'h0000, 1'b1, 0, 1'b0};
        tbl[4] = '{72'h1, 1, 16'h8005, 1'b1, 3, 1'b0};
        tbl[5] = '{72'h01, 8, 16'h8004, 1'b0, 0, 1'b0};
        tbl[6] = '{72'h0, 1, 16'h0001, 1'b0, 1, 1'b0};
        tbl[7] = '{72'h01, 8, 16'h8005, 1'b1, 0, 1'b1};
        tbl[8] = '{72'h313233343536373839, 72, 16'hFEE8, 1'b1, 0, 1'b1};
        tbl[9] = '{72'h0000, 16, 16'h0000, 1'b1, 2, 1'b0};

        rst = 1'b1; load = 1'b0; d_finish = 1'b0; crc_in = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset_data_out", 72'(data_out), 72'd0);
        check("reset_data_valid", 72'(data_valid), 72'd0);
        check("reset_chk_valid", 72'(chk_valid), 72'd0);
        check("reset_crc_ok", 72'(crc_ok), 72'd0);
        check("reset_crc_err", 72'(crc_err), 72'd0);
`ifdef CRC16_CHK_ERRCNT_EN
        check("reset_err_cnt", 72'(err_cnt), 72'd0);
`endif
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NTBL; i++) begin
            send_frame(tbl[i]);
            after_frame(tbl[i].gap);
        end
        load = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end

        // Reset asserted while CRC bit 7 is on the input.
        abort_byte = 8'hA5;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            crc_in   = abort_byte[7 - i];
            d_finish = (i == 7);
            @(posedge clk); #1;
        end
        d_finish = 1'b0;
        for (int i = 0; i < 7; i++) begin
            crc_in = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("abort_data_out", 72'(data_out), 72'd0);
        check("abort_data_valid", 72'(data_valid), 72'd0);
        check("abort_chk_valid", 72'(chk_valid), 72'd0);
        check("abort_crc_ok", 72'(crc_ok), 72'd0);
        check("abort_crc_err", 72'(crc_err), 72'd0);
`ifdef CRC16_CHK_ERRCNT_EN
        check("abort_err_cnt", 72'(err_cnt), 72'd0);
        exp_err_cnt = 0;
`endif
        rx_q.delete();
        crc_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
        end
        send_frame(tbl[0]);
        after_frame(2);

        // Long run of corrupt frames to drive the error count into saturation.
        bad_frame = '{72'h0, 1, 16'h0001, 1'b0, 0, 1'b0};
        for (int i = 0; i < 300; i++) begin
            send_frame(bad_frame);
            after_frame(0);
        end
        load = 1'b0;
        send_frame(tbl[3]);
        after_frame(1);
        load = 1'b0;

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("pending_verdicts", 72'(exp_q.size()), 72'd0);
`ifdef CRC16_CHK_ERRCNT_EN
        check("err_cnt_saturated", 72'(err_cnt), 72'd255);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crc16_serial_checker.md
# crc16_serial_checker

Serial CRC-16 checker: the receive-side partner of the team's serial CRC-16 encoder. It accepts a bit stream of data bits followed by the 16-bit CRC the encoder appends, MSB first. It runs the same LFSR over both parts and reports pass/fail once per frame. It passes data bits through with a one-cycle delay so downstream logic can consume the payload while the check runs.

## Interface
Parameters:
- none (polynomial and width are fixed package constants)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (rst = 0 resets)
- load  input  1  frame start strobe; honoured only in IDLE
- d_finish  input  1  marks the cycle carrying the last data bit; honoured only in DATA
- crc_in  input  1  serial input bit (data bits, then 16 CRC bits)
- data_out  output  1  registered copy of each data bit
- data_valid  output  1  high for one cycle per data bit on data_out
- chk_valid  output  1  one-cycle pulse: verdict available
- crc_ok  output  1  frame passed; held until next accepted load
- crc_err  output  1  frame failed; held until next accepted load
- err_cnt  output  8  frame error count (only with CRC16_CHK_ERRCNT_EN)

## Operation
- Generator polynomial: x^16+x^15+x^2+1 (0x8005). Init 0x0000. No reflection, no final XOR.
- LFSR update per sampled bit b, with fb = r[15]^b:
  - r[0] = fb
  - r[2] = r[1]^fb
  - r[15] = r[14]^fb
  - all other r[i] = r[i-1]
- States: IDLE, DATA, CRC, DONE.
  - IDLE: r held at 0, bit counter at 0. load=1 → DATA, and clears crc_ok/crc_err.
  - DATA: each cycle samples crc_in into the LFSR and sets data_out=crc_in, data_valid=1. d_finish=1 in the same cycle → CRC. The bit sampled with d_finish is the last data bit.
  - CRC: samples 16 bits into the LFSR with a 4-bit counter 0..15; data_valid=0. After count 15 → DONE.
  - DONE: registers crc_ok=(r==0), crc_err=(r!=0), chk_valid=1, then → IDLE.
- Minimum frame is 1 data bit (d_finish on the first DATA cycle). There is no maximum data length.
- Ignored inputs:
  - load outside IDLE, including during DONE. load is accepted in the cycle in which chk_valid is high.
  - d_finish outside DATA.
  - crc_in in IDLE and DONE.
- Reset mid-frame: returns to IDLE, all outputs cleared, no chk_valid produced.

## Timing
- Reset values: data_out=0, data_valid=0, chk_valid=0, crc_ok=0, crc_err=0, err_cnt=0, state IDLE, r=0.
- Edge of accepted load = E0. The first data bit is sampled at E1.
- data_out/data_valid lag their input bit by one cycle.
- If the last data bit is sampled at edge Ed:
  - CRC bits are sampled at Ed+1..Ed+16.
  - DONE occupies the cycle after Ed+16.
  - chk_valid, crc_ok and crc_err update at Ed+17.
  - chk_valid falls at Ed+18.
- Back-to-back frames: load asserted during the chk_valid cycle starts the next frame; the minimum gap between frames is 0 idle cycles.

## Configuration
- Macro CRC16_CHK_ERRCNT_EN.
- Defined: the err_cnt port exists. An 8-bit counter increments on each chk_valid with crc_err=1, saturates at 255, and clears only on reset.
- Undefined: no err_cnt port and no counter logic. All other behaviour is identical.

## Structure
- Package crc16_pkg holds:
  - CRC_W = 16
  - CRC_POLY = 16'h8005
  - CRC_INIT = 16'h0000
  - state enum (IDLE/DATA/CRC/DONE)
  - counter width 4
- Sub-module crc16_serial_lfsr: register r with clear, shift-enable and bit input; exposes r and a zero flag. The encoder may reuse it.
- The top level holds the FSM, bit counter, pass-through register and verdict/error-count registers.

## Test plan
- Byte 0x01 then CRC 0x8005 (24 bits, MSB first) → one chk_valid pulse, crc_ok=1, crc_err=0; 8 data_valid pulses reproduce 0x01.
- ASCII "123456789" (72 bits) then CRC 0xFEE8 → crc_ok=1; the same frame with data bit 5 flipped → crc_err=1, err_cnt=1 (macro on).
- 1-bit frame (d_finish on the first DATA cycle, bit 0) then CRC 0x0000 → crc_ok=1; chk_valid rises exactly 17 edges after the data bit edge.
- Two back-to-back frames, load during the chk_valid cycle → both verdicts correct; load pulses in DATA/CRC/DONE are ignored.
- rst pulled low at CRC bit 7 → all outputs 0 immediately, no chk_valid; the next frame checks correctly.
- 300 consecutive corrupt frames (macro on) → err_cnt saturates at 255; macro off → build has no err_cnt port and results are unchanged.
